regfile_wb_arbiter: RTL

Shares the register file's single write port (write-enable, write address, write data) between two writeback sources: src0 is ALU writeback and src1 is load writeback.
- Each source owns a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter issues at most one register write per cycle.
- Writes to register 0 are absorbed and never issued.
- Outputs flag when a register-file read address matches a pending buffered write, so decode can stall.

---
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between two writeback
// sources (src0 = ALU, src1 = load). Each source has a one-entry holding
// buffer. A round-robin arbiter drains at most one buffer per cycle.
// Writes to register 0 are consumed silently. Pending buffered writes are
// reported against two read addresses so decode can stall.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   s0_* / s1_*           valid/ready write offers (addr, data) per source
//   we, waddr, wdata      register file write port
//   raddr1, raddr2        read addresses to check for hazards
//   pend1, pend2          read address hits a buffered, uncommitted write
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s1_valid,
   output logic              s1_ready,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [DATA_W-1:0] s1_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic              pend1,
   output logic              pend2
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_t;

   // Round-robin pointer: which source wins when both holds are valid.
   typedef enum logic {
      RR_S0 = 1'b0,
      RR_S1 = 1'b1
   } rr_t;

   rr_t  rr_q, rr_d;
   logic hold0_valid_q, hold0_valid_d;
   logic hold1_valid_q, hold1_valid_d;
   wb_t  hold0_q, hold0_d;
   wb_t  hold1_q, hold1_d;

   logic grant0, grant1;
   logic accept0, accept1;
   wb_t  win;

   // Arbitration, handshake and write-port drive; everything is held quiet in reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      win    = '0;

      if (!reset) begin
         grant0 = hold0_valid_q & (!hold1_valid_q | (rr_q == RR_S0));
         grant1 = hold1_valid_q & (!hold0_valid_q | (rr_q == RR_S1));
      end

      if (grant0)      win = hold0_q;
      else if (grant1) win = hold1_q;

      s0_ready = !reset & (!hold0_valid_q | grant0);
      s1_ready = !reset & (!hold1_valid_q | grant1);
      accept0  = s0_valid & s0_ready;
      accept1  = s1_valid & s1_ready;

      // A granted register-0 entry is consumed without a write.
      we    = (grant0 | grant1) & (win.addr != '0);
      waddr = win.addr;
      wdata = win.data;
   end

   // Hazard query includes the entry being issued this cycle (not yet readable).
   always_comb begin
      pend1 = !reset & (raddr1 != '0) &
              ((hold0_valid_q & (hold0_q.addr == raddr1)) |
               (hold1_valid_q & (hold1_q.addr == raddr1)));
      pend2 = !reset & (raddr2 != '0) &
              ((hold0_valid_q & (hold0_q.addr == raddr2)) |
               (hold1_valid_q & (hold1_q.addr == raddr2)));
   end

   // Next state: pointer flips to the other source on any grant; an accept
   // overrides a same-cycle drain so the hold stays valid with new contents.
   always_comb begin
      rr_d          = rr_q;
      hold0_valid_d = hold0_valid_q;
      hold1_valid_d = hold1_valid_q;
      hold0_d       = hold0_q;
      hold1_d       = hold1_q;

      if (grant0)      rr_d = RR_S1;
      else if (grant1) rr_d = RR_S0;

      if (accept0) begin
         hold0_valid_d = 1'b1;
         hold0_d       = '{addr: s0_addr, data: s0_data};
      end else if (grant0) begin
         hold0_valid_d = 1'b0;
      end

      if (accept1) begin
         hold1_valid_d = 1'b1;
         hold1_d       = '{addr: s1_addr, data: s1_data};
      end else if (grant1) begin
         hold1_valid_d = 1'b0;
      end
   end

   // Control state; reset drops buffered writes and favours src0.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q          <= RR_S0;
         hold0_valid_q <= 1'b0;
         hold1_valid_q <= 1'b0;
      end else begin
         rr_q          <= rr_d;
         hold0_valid_q <= hold0_valid_d;
         hold1_valid_q <= hold1_valid_d;
      end
   end

   // Payload registers are qualified by the valid flags and need no reset.
   always_ff @(posedge clk) begin
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
   end

endmodule
